// File: rtl/ropuf_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ropuf_pair_scheduler
// Description : Sequences RO-pair frequency measurements for one PUF challenge
//               and assembles the comparison bits into a response word.
// Revision    : 1.0 - initial release
// ============================================================================

module ropuf_pair_scheduler #(
  parameter int WINDOW = 1024,
  parameter int NPAIRS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        challenge,
  input  logic [15:0]       cnt_a,
  input  logic [15:0]       cnt_b,
  output logic [3:0]        sel_a,
  output logic [3:0]        sel_b,
  output logic              ro_en,
  output logic              cnt_clr,
  output logic              busy,
  output logic              done,
  output logic [NPAIRS-1:0] response
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [15:0] c_win_last = 16'(WINDOW - 1);
  localparam logic [2:0]  c_k_last   = 3'(NPAIRS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_timer;
  logic [2:0]        r_k;
  logic [3:0]        r_sel_a;
  logic [3:0]        r_sel_b;
  logic [NPAIRS-1:0] r_response;
  logic              w_win_end;
  logic              w_last_pair;
  logic              w_a_gt_b;

  assign w_win_end   = (r_timer == c_win_last);
  assign w_last_pair = (r_k == c_k_last);
  // Ties must resolve to 0, so strictly-greater is the rule.
  assign w_a_gt_b    = (cnt_a > cnt_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    ro_en   = 1'b0;
    cnt_clr = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_clr = 1'b1;
        w_next  = S_MEASURE;
      end
      S_MEASURE: begin
        ro_en = 1'b1;
        if (w_win_end) begin
          w_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        w_next = w_last_pair ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer    <= 16'd0;
      r_k        <= 3'd0;
      r_sel_a    <= 4'd0;
      r_sel_b    <= 4'd0;
      r_response <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k        <= 3'd0;
            r_sel_a    <= challenge;
            r_sel_b    <= challenge + 4'd1;
            r_response <= '0;
          end
        end
        S_CLEAR: begin
          r_timer <= 16'd0;
        end
        S_MEASURE: begin
          r_timer <= r_timer + 16'd1;
        end
        S_COMPARE: begin
          for (int i = 0; i < NPAIRS; i++) begin
            if (r_k == 3'(i)) begin
              r_response[i] <= w_a_gt_b;
            end
          end
          // Selects advance only when another pair follows, so the last
          // pair's indices stay visible until the next challenge.
          if (!w_last_pair) begin
            r_k     <= r_k + 3'd1;
            r_sel_a <= r_sel_a + 4'd2;
            r_sel_b <= r_sel_b + 4'd2;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sel_a    = r_sel_a;
  assign sel_b    = r_sel_b;
  assign response = r_response;

endmodule

`default_nettype wire

// File: doc/ropuf_pair_scheduler.md
ROPUF_PAIR_SCHEDULER -- requirements
Module: ropuf_pair_scheduler

Interface
REQ-001 Parameter WINDOW, default 1024, measurement window length in clk cycles (legal range 1..65535).
REQ-002 Parameter NPAIRS, default 8, number of RO pairs measured per challenge, which is also the response width (legal range 1..8).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 start  input  1  request to run one challenge; sampled only in IDLE.
REQ-006 challenge  input  4  base oscillator index, latched when start is accepted.
REQ-007 cnt_a  input  16  unsigned edge count from the RO-A frequency counter.
REQ-008 cnt_b  input  16  unsigned edge count from the RO-B frequency counter.
REQ-009 sel_a  output  4  oscillator index driving the RO-A 4-to-16 select decoder.
REQ-010 sel_b  output  4  oscillator index driving the RO-B 4-to-16 select decoder.
REQ-011 ro_en  output  1  oscillator enable and counter count-enable.
REQ-012 cnt_clr  output  1  synchronous clear pulse to both frequency counters.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 response  output  NPAIRS  PUF response bits; bit k is the result for pair k.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, MEASURE, COMPARE and DONE, all registered.
REQ-017 In IDLE, start=1 SHALL latch challenge, set pair index k=0, clear response to 0 and move to CLEAR on the next cycle.
REQ-018 While busy=1, start SHALL be ignored and SHALL NOT re-latch challenge.
REQ-019 The select outputs SHALL follow these rules, using 4-bit modulo-16 wrap-around.
- sel_a = challenge + 2k.
- sel_b = challenge + 2k + 1.
- Both SHALL be registered and stable from CLEAR through COMPARE of pair k.
REQ-020 CLEAR SHALL last exactly 1 cycle with cnt_clr=1 and ro_en=0, then move to MEASURE with the window timer at 0.
REQ-021 MEASURE SHALL hold ro_en=1 for exactly WINDOW consecutive cycles, then move to COMPARE.
REQ-022 COMPARE SHALL last 1 cycle with ro_en=0 and SHALL write response[k] = (cnt_a > cnt_b).
- The comparison is unsigned.
- A tie (cnt_a == cnt_b) yields 0.
REQ-023 From COMPARE, the FSM SHALL go to DONE if k == NPAIRS-1; otherwise it SHALL set k=k+1 and go to CLEAR.
REQ-024 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-025 response SHALL hold its value after DONE until the next accepted start.
REQ-026 ro_en SHALL be high only in MEASURE, and cnt_clr SHALL be high only in CLEAR.
REQ-027 Latency: if start is accepted at cycle 0, done SHALL be high at cycle NPAIRS*(WINDOW+2)+1.
REQ-028 The window timer SHALL be at least 16 bits wide and SHALL NOT wrap before reaching WINDOW.

Reset
REQ-029 While rst=1, the following SHALL hold: state=IDLE, k=0, sel_a=0, sel_b=0, ro_en=0, cnt_clr=0, busy=0, done=0, response=0.
REQ-030 rst asserted mid-operation SHALL take effect immediately, with no done pulse and no partial response retained.
REQ-031 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification (WINDOW=4, NPAIRS=8 unless stated)
REQ-032 Basic run: challenge=0, start at cycle 0, cnt_a > cnt_b on even pairs only.
- done is high at cycle 49.
- response = 8'b0101_0101.
- busy is high for cycles 1..49.
REQ-033 Wrap-around: challenge=15.
- Pair 0 gives sel_a=15, sel_b=0.
- Pair 7 gives sel_a=13, sel_b=14.
REQ-034 Tie and boundary: cnt_a=cnt_b=16'hFFFF on all pairs gives response=0; cnt_a=16'hFFFF, cnt_b=0 on all pairs gives response=8'hFF.
REQ-035 Cycle timing: within each pair, cnt_clr is high for exactly 1 cycle, followed by exactly 4 ro_en cycles, followed by 1 COMPARE cycle.
REQ-036 Start while busy: start pulsed at cycle 10 with challenge=9.
- The latched challenge is unchanged.
- done is still high at cycle 49, with no second run.
REQ-037 Reset mid-run: rst pulsed at cycle 20.
- All outputs go to 0 asynchronously.
- No done pulse occurs.
- A new start afterwards completes 49 cycles later.
